// File: rtl/mem_ctrl_stallreq_if.sv
// Bundle of the fetch port, load/store port, byte-wide RAM port and stall requests
// that connect a core front end to the byte-serial memory controller.
interface mem_ctrl_stallreq_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  logic        stall_from_if;
  logic        stall_from_mem;

  // Controller side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           stall_from_if, stall_from_mem
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           stall_from_if, stall_from_mem
  );
endinterface

// File: rtl/mem_ctrl_stallreq.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store onto a
// single 8-bit synchronous RAM port, with stall requests back to the pipeline.
module mem_ctrl_stallreq #(
  parameter logic [31:0] IDLE_ADDR = 32'h0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  mem_ctrl_stallreq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] buf_q, buf_d;

  logic [1:0]  cap_idx;
  logic [31:0] buf_ins;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*idx +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  // ram_din in cycle k carries the byte addressed in cycle k-1
  assign cap_idx = cnt_q[1:0] - 2'd1;
  assign buf_ins = put_byte(buf_q, cap_idx, bus.ram_din);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    buf_d       = buf_q;

    if (rdy_in) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = 3'd0;
          // A port that completed this cycle still shows its request; skip it once
          if (bus.mem_req && !mem_done_q) begin
            state_d = bus.mem_we ? MEM_WR : MEM_RD;
            base_d  = bus.mem_addr;
            wdata_d = bus.mem_wdata;
            len_d   = size_len(bus.mem_size);
            buf_d   = 32'h0;
          end else if (bus.if_req && !if_done_q) begin
            state_d = IF_RD;
            base_d  = bus.if_addr;
            len_d   = 3'd4;
            buf_d   = 32'h0;
          end
        end
        IF_RD, MEM_RD: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) begin
            buf_d = buf_ins;
          end
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == IF_RD) begin
              if_inst_d = buf_ins;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = buf_ins;
              mem_done_d  = 1'b1;
            end
          end
        end
        MEM_WR: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q - 3'd1) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            mem_done_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    ram_a    = IDLE_ADDR;
    ram_dout = 8'h00;
    ram_wr   = 1'b0;
    if (state_q != IDLE) begin
      ram_a = base_q + {29'd0, cnt_q};
    end
    if (state_q == MEM_WR) begin
      ram_dout = get_byte(wdata_q, cnt_q[1:0]);
      ram_wr   = rdy_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Latched request fields are only consumed outside IDLE, so they need no reset
  always_ff @(posedge clk_in) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    len_q   <= len_d;
    buf_q   <= buf_d;
  end

  assign bus.if_done        = if_done_q;
  assign bus.if_inst        = if_inst_q;
  assign bus.mem_done       = mem_done_q;
  assign bus.mem_rdata      = mem_rdata_q;
  assign bus.ram_a          = ram_a;
  assign bus.ram_dout       = ram_dout;
  assign bus.ram_wr         = ram_wr;
  assign bus.stall_from_if  = rst_n_in & bus.if_req & ~if_done_q;
  assign bus.stall_from_mem = rst_n_in & bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl_stallreq.sv
// Directed bench for mem_ctrl_stallreq: table of single transactions against a
// byte RAM model, plus arbitration, rdy_in freeze and mid-access reset sequences.
module tb_mem_ctrl_stallreq;
  localparam logic [31:0] IDLE_A = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  logic rdy;

  mem_ctrl_stallreq_if bus();

  mem_ctrl_stallreq #(.IDLE_ADDR(IDLE_A)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preload image written by the stimulus, write log written by the clocked model
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wlog_a [64];
  logic [7:0]  wlog_d [64];
  int          wr_cnt = 0;
  logic [7:0]  ram_din_r = 8'h00;

  function automatic logic [7:0] rd(input logic [31:0] a);
    logic [7:0] b;
    b = ram.exists(a) ? ram[a] : 8'h00;
    for (int i = 0; i < 64; i++)
      if (i < wr_cnt && wlog_a[i] == a) b = wlog_d[i];
    return b;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
  endfunction

  always @(posedge clk) begin
    ram_din_r <= rd(bus.ram_a);
    if (bus.ram_wr) begin
      wlog_a[wr_cnt] <= bus.ram_a;
      wlog_d[wr_cnt] <= bus.ram_dout;
      wr_cnt         <= wr_cnt + 1;
    end
  end
  assign bus.ram_din = ram_din_r;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;
  logic [31:0] last_inst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;    // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] init;  // RAM word preloaded at addr (little-endian)
    logic [31:0] exp;   // fetched word, load data, or RAM word after store
    int          lat;   // accepting edge to done cycle
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int   n, cyc, wr0;
    logic seen, done;
    n = (v.op == 2'd0) ? 4 : (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) ram[v.addr + 32'(i)] = v.init[8*i +: 8];
    @(negedge clk);
    if (v.op == 2'd0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = (v.op == 2'd2);
      bus.mem_addr  = v.addr;
      bus.mem_size  = v.size;
      bus.mem_wdata = v.wdata;
    end
    wr0  = wr_cnt;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      done = (v.op == 2'd0) ? bus.if_done : bus.mem_done;
      if (cyc == 1)
        chk("stall_busy", 32'((v.op == 2'd0) ? bus.stall_from_if : bus.stall_from_mem), 32'd1);
      if (done) seen = 1'b1;
      else if (cyc - 1 < n) begin
        chk("ram_a", bus.ram_a, v.addr + 32'(cyc - 1));
        if (v.op == 2'd2) begin
          chk("ram_wr", 32'(bus.ram_wr), 32'd1);
          chk("ram_dout", 32'(bus.ram_dout), 32'(v.wdata[8*(cyc-1) +: 8]));
        end else begin
          chk("ram_wr_rd", 32'(bus.ram_wr), 32'd0);
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc - 1), 32'(v.lat));
    if (v.op == 2'd0) begin
      chk("if_inst", bus.if_inst, v.exp);
      chk("stall_if_done", 32'(bus.stall_from_if), 32'd0);
      chk("rdata_hold", bus.mem_rdata, last_rdata);
      last_inst = v.exp;
    end else begin
      chk("stall_mem_done", 32'(bus.stall_from_mem), 32'd0);
      chk("inst_hold", bus.if_inst, last_inst);
      if (v.op == 2'd1) begin
        chk("mem_rdata", bus.mem_rdata, v.exp);
        last_rdata = v.exp;
      end else begin
        chk("rdata_unchanged", bus.mem_rdata, last_rdata);
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'((v.op == 2'd0) ? bus.if_done : bus.mem_done), 32'd0);
    if (v.op == 2'd2) begin
      chk("wr_count", 32'(wr_cnt - wr0), 32'(n));
      chk("ram_word", rd_word(v.addr), v.exp);
    end
  endtask

  initial begin
    int   cyc;
    logic seen;

    vecs[0] = '{op: 2'd0, addr: 32'h0000_0100, size: 2'd2, wdata: 32'h0, init: 32'h0050_0013, exp: 32'h0050_0013, lat: 5};
    vecs[1] = '{op: 2'd2, addr: 32'h0000_2000, size: 2'd2, wdata: 32'hDEAD_BEEF, init: 32'h0, exp: 32'hDEAD_BEEF, lat: 4};
    vecs[2] = '{op: 2'd1, addr: 32'h0000_0010, size: 2'd0, wdata: 32'h0, init: 32'h0000_0080, exp: 32'h0000_0080, lat: 2};
    vecs[3] = '{op: 2'd1, addr: 32'h0000_0020, size: 2'd1, wdata: 32'h0, init: 32'hCAFE_1234, exp: 32'h0000_1234, lat: 3};
    vecs[4] = '{op: 2'd1, addr: 32'h0000_0030, size: 2'd2, wdata: 32'h0, init: 32'h89AB_CDEF, exp: 32'h89AB_CDEF, lat: 5};
    vecs[5] = '{op: 2'd2, addr: 32'h0000_0040, size: 2'd0, wdata: 32'h1122_33AA, init: 32'h5555_5555, exp: 32'h5555_55AA, lat: 1};
    vecs[6] = '{op: 2'd2, addr: 32'h0000_0050, size: 2'd1, wdata: 32'hFFFF_7788, init: 32'h0, exp: 32'h0000_7788, lat: 2};
    vecs[7] = '{op: 2'd0, addr: 32'hFFFF_FFFE, size: 2'd2, wdata: 32'h0, init: 32'h0403_0201, exp: 32'h0403_0201, lat: 5};
    vecs[8] = '{op: 2'd1, addr: 32'h0000_0060, size: 2'd3, wdata: 32'h0, init: 32'h0102_0304, exp: 32'h0102_0304, lat: 5};

    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_size  = 2'b00;
    bus.mem_wdata = 32'h0;
    last_rdata = 32'h0;
    last_inst  = 32'h0;

    // Reset state, requests held high to see the stall gating
    repeat (2) @(negedge clk);
    chk("rst_if_done", 32'(bus.if_done), 32'd0);
    chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
    chk("rst_if_inst", bus.if_inst, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_ram_a", bus.ram_a, IDLE_A);
    chk("rst_stall_if", 32'(bus.stall_from_if), 32'd0);
    chk("rst_stall_mem", 32'(bus.stall_from_mem), 32'd0);
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ram_a", bus.ram_a, IDLE_A);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Simultaneous requests: load byte wins, fetch waits with stall held
    ram[32'h10] = 8'h80;
    for (int i = 0; i < 4; i++) ram[32'h300 + 32'(i)] = 8'h44 - 8'(i * 8'h11);
    @(negedge clk);
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h300;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h10;
    bus.mem_size  = 2'b00;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      chk("sim_stall_if", 32'(bus.stall_from_if), 32'd1);
      if (bus.mem_done) seen = 1'b1;
    end
    chk("sim_mem_seen", 32'(seen), 32'd1);
    chk("sim_mem_lat", 32'(cyc - 1), 32'd2);
    chk("sim_mem_rdata", bus.mem_rdata, 32'h0000_0080);
    chk("sim_stall_mem", 32'(bus.stall_from_mem), 32'd0);
    last_rdata  = 32'h0000_0080;
    bus.mem_req = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("sim_fetch_a0", bus.ram_a, 32'h300);
      if (bus.if_done) seen = 1'b1;
    end
    chk("sim_if_seen", 32'(seen), 32'd1);
    chk("sim_if_lat", 32'(cyc), 32'd6);
    chk("sim_if_inst", bus.if_inst, 32'h1122_3344);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Half store with rdy_in low for three cycles after the first byte
    @(negedge clk);
    cyc = wr_cnt;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h400;
    bus.mem_size  = 2'b01;
    bus.mem_wdata = 32'h0000_A1B2;
    @(negedge clk);
    chk("rdy_wr0", 32'(bus.ram_wr), 32'd1);
    chk("rdy_dout0", 32'(bus.ram_dout), 32'hB2);
    @(negedge clk);
    chk("rdy_a1", bus.ram_a, 32'h401);
    rdy = 1'b0;
    #1;
    chk("rdy_low_wr", 32'(bus.ram_wr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdy_hold_wr", 32'(bus.ram_wr), 32'd0);
      chk("rdy_hold_a", bus.ram_a, 32'h401);
      chk("rdy_no_done", 32'(bus.mem_done), 32'd0);
    end
    rdy = 1'b1;
    #1;
    chk("rdy_wr1", 32'(bus.ram_wr), 32'd1);
    chk("rdy_dout1", 32'(bus.ram_dout), 32'hA1);
    @(negedge clk);
    chk("rdy_done", 32'(bus.mem_done), 32'd1);
    bus.mem_req = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_done_held", 32'(bus.mem_done), 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_done_clear", 32'(bus.mem_done), 32'd0);
    chk("rdy_wr_count", 32'(wr_cnt - cyc), 32'd2);
    chk("rdy_ram_half", {16'h0, rd(32'h401), rd(32'h400)}, 32'h0000_A1B2);
    chk("rdy_rdata_kept", bus.mem_rdata, last_rdata);

    // Reset during cycle 2 of a fetch, then a full fetch from IDLE
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    repeat (3) @(negedge clk);
    chk("rstm_a2", bus.ram_a, 32'h102);
    rst_n = 1'b0;
    #1;
    chk("rstm_ram_a", bus.ram_a, IDLE_A);
    chk("rstm_stall_if", 32'(bus.stall_from_if), 32'd0);
    chk("rstm_if_inst", bus.if_inst, 32'h0);
    chk("rstm_mem_rdata", bus.mem_rdata, 32'h0);
    @(negedge clk);
    chk("rstm_no_done", 32'(bus.if_done), 32'd0);
    rst_n = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("rstm_a0", bus.ram_a, 32'h100);
      if (bus.if_done) seen = 1'b1;
    end
    chk("rstm_if_seen", 32'(seen), 32'd1);
    chk("rstm_if_lat", 32'(cyc), 32'd6);
    chk("rstm_if_inst2", bus.if_inst, 32'h0050_0013);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("rstm_done_pulse", 32'(bus.if_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_stallreq.md
MEM_CTRL_STALLREQ -- requirements
Module: mem_ctrl_stallreq

Interface
REQ-001 Parameter: IDLE_ADDR, 32'h0, value driven on ram_a when no access is in flight.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global ready; low freezes the block.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_done.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_done  output  1  one-cycle pulse: if_inst valid.
REQ-008 if_inst  output  32  fetched word, little-endian.
REQ-009 mem_req  input  1  load/store request, held high until mem_done.
REQ-010 mem_we  input  1  1 = store, 0 = load.
REQ-011 mem_addr  input  32  load/store byte address.
REQ-012 mem_size  input  2  00 byte, 01 half, 10/11 word.
REQ-013 mem_wdata  input  32  store data, low bytes used.
REQ-014 mem_done  output  1  one-cycle pulse: access complete, mem_rdata valid for loads.
REQ-015 mem_rdata  output  32  load data, zero-extended.
REQ-016 ram_din  input  8  RAM read byte, valid one cycle after its address.
REQ-017 ram_a  output  32  RAM byte address.
REQ-018 ram_dout  output  8  RAM write byte.
REQ-019 ram_wr  output  1  RAM write strobe.
REQ-020 stall_from_if  output  1  fetch-pending stall request to stallctrl.
REQ-021 stall_from_mem  output  1  memory-pending stall request to stallctrl.

Function
REQ-022 FSM states SHALL be IDLE, IF_RD, MEM_RD, MEM_WR; byte counter cnt 0..4; byte count n = 4 for fetch, 1/2/4 per mem_size for mem access.
REQ-023 In IDLE the block SHALL accept mem_req before if_req when both are high, latch address, size, wdata and we, set cnt = 0, and enter MEM_RD/MEM_WR/IF_RD.
REQ-024 ram_a, ram_dout and ram_wr SHALL be combinational from state, cnt and latched fields; in IDLE ram_a = IDLE_ADDR, ram_wr = 0, ram_dout = 0.
REQ-025 Read states: cycle k (k = 0..n-1) drives ram_a = base+k; the edge ending cycle k (k = 1..n) captures ram_din into byte k-1; after that capture at k = n, return to IDLE with done set.
REQ-026 MEM_WR: cycle k (k = 0..n-1) drives ram_wr = 1, ram_a = base+k, ram_dout = wdata byte k; after k = n-1, return to IDLE with mem_done set.
REQ-027 Latency from accepting edge to done cycle: n+1 cycles for reads (5 for fetch), n cycles for writes.
REQ-028 if_done/mem_done SHALL be registered, high for exactly one cycle; if_inst/mem_rdata SHALL hold until the next completion of the same port.
REQ-029 In the done cycle the block SHALL NOT re-accept the port that just completed; it may accept the other port.
REQ-030 An access in flight SHALL never be aborted or preempted; new requests wait in IDLE.
REQ-031 Address arithmetic base+k SHALL wrap modulo 2^32; no alignment check.
REQ-032 Unused upper bytes of mem_rdata SHALL be 0 for byte/half loads; mem_rdata is unchanged by stores.
REQ-033 stall_from_if = if_req & ~if_done; stall_from_mem = mem_req & ~mem_done (combinational).
REQ-034 While rdy_in = 0, state, cnt, captured data and done flags SHALL hold and ram_wr SHALL be 0; a done pulse held over a rdy_in-low period stays high until the first rdy_in-high cycle ends.

Reset
REQ-035 rst_n_in low SHALL immediately force IDLE, cnt = 0, if_done = mem_done = 0, if_inst = mem_rdata = 0, ram_wr = 0, ram_a = IDLE_ADDR, and stall_from_if = stall_from_mem = 0.
REQ-036 Reset mid-access SHALL abandon the access with no done pulse; after release, pending requests are re-accepted from IDLE.

Verification
REQ-037 Fetch: if_addr = 0x100, RAM bytes 13,00,50,00 -> ram_a 0x100..0x103, if_done in cycle 5 after accept, if_inst = 0x00500013, stall_from_if low in the done cycle.
REQ-038 Store word: mem_addr = 0x2000, wdata = 0xDEADBEEF -> ram_wr high 4 cycles, bytes EF,BE,AD,DE at 0x2000..0x2003, mem_done after cycle 4.
REQ-039 Simultaneous if_req and mem_req (load byte at 0x10, RAM = 0x80) -> MEM served first, mem_rdata = 0x00000080, stall_from_if high throughout, fetch starts in the mem_done cycle.
REQ-040 Fetch at 0xFFFFFFFE -> ram_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-041 rdy_in low for 3 cycles during a half store -> ram_wr 0 while low, no byte lost or repeated, mem_done one cycle after the second written byte.
REQ-042 rst_n_in low during cycle 2 of a fetch -> immediate IDLE, no if_done; after release with if_req still high, a full 5-cycle fetch repeats.
